// File: rtl/multicycle_slice_adder.sv
// Wide adder that reuses one 4-bit ripple adder, one slice per cycle.
// Valid/ready in, valid/ready out; the slice carry is held in a register.
//
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, a, b, carry_in : operand handshake
//   out_valid/out_ready, sum, carry_out : result handshake
//   busy : high while an operation is in RUN or DONE

module ripple_adder_4bit_structural (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;
  logic [3:0] w_p;
  logic [3:0] w_g;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign w_p[g]     = i_a[g] ^ i_b[g];
    assign w_g[g]     = i_a[g] & i_b[g];
    assign o_sum[g]   = w_p[g] ^ w_c[g];
    assign w_c[g + 1] = w_g[g] | (w_p[g] & w_c[g]);
  end

  assign o_cout = w_c[4];
endmodule

module multicycle_slice_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  logic [IDX_W+1:0] w_base;
  logic [3:0]       w_a_sl;
  logic [3:0]       w_b_sl;
  logic [3:0]       w_s;
  logic             w_co;
  logic             w_last;

  // Bit offset of the current slice: idx * 4.
  assign w_base = {r_idx, 2'b00};
  assign w_a_sl = r_a[w_base +: 4];
  assign w_b_sl = r_b[w_base +: 4];
  assign w_last = (r_idx == LAST);

  ripple_adder_4bit_structural u_add (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)  w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= w_s;
          r_carry            <= w_co;
          // Wrap explicitly so non-power-of-two slice counts restart cleanly.
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_cout      <= w_co;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_cout;
endmodule

// File: tb/tb_multicycle_slice_adder.sv
// Scoreboard bench for multicycle_slice_adder (WIDTH=16).
// Driver pushes expected {cout,sum}; monitor pops on each output handshake.

module tb_multicycle_slice_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        carry_out;
  logic        busy;

  logic [16:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;
  int rdy_mode = 0;

  multicycle_slice_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [16:0] e;
      n_hs++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h", {carry_out, sum});
      end else begin
        e = sb_q.pop_front();
        if ({carry_out, sum} !== e) begin
          n_fail++;
          $display("FAIL result got=%h exp=%h", {carry_out, sum}, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc);
    bit ok;
    ok = 0;
    @(negedge clk);
    a = ta;
    b = tb_;
    carry_in = tc;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) sb_q.push_back({1'b0, ta} + {1'b0, tb_} + {16'b0, tc});
    #1 in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout got=%0d exp=0", sb_q.size());
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] r;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int hs0;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h1_0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF};
    vecs[2] = '{16'h1234, 16'h4321, 1'b0, 17'h0_5555};
    vecs[3] = '{16'h00FF, 16'h0F01, 1'b0, 17'h0_1000};

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Zero operands and latency: out_valid on the 4th edge after accept.
    rdy_mode = 0;
    send(16'h0000, 16'h0000, 1'b0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd4);
    drain();

    // Hand-computed vectors; check against the table too.
    foreach (vecs[i]) begin
      chk("table_vec", 32'({1'b0, vecs[i].a} + {1'b0, vecs[i].b}
                           + {16'b0, vecs[i].c}), 32'(vecs[i].r));
      send(vecs[i].a, vecs[i].b, vecs[i].c);
    end
    drain();

    // Backpressure in DONE; A5A5 + 0F0F = B4B4.
    rdy_mode = 2;
    @(posedge clk);
    send(16'hA5A5, 16'h0F0F, 1'b0);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = 1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(lat), 32'd1);
    hs0 = n_hs;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 16'h1111;
        b = 16'h2222;
        carry_in = 1'b1;
        in_valid = 1'b1;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'({carry_out, sum}), 32'h0_B4B4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (5) @(negedge clk);
    chk("bp_one_handoff", 32'(n_hs - hs0), 32'd1);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_sum_held", 32'(sum), 32'h0000_B4B4);

    // Reset two cycles into RUN aborts the operation.
    send(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(carry_out), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("rst_no_result", 32'(out_valid), 32'd0);
    send(16'h0003, 16'h0006, 1'b0);
    drain();
    chk("after_rst_sum", 32'({carry_out, sum}), 32'h0_0009);

    // Random operands with random consumer backpressure.
    rdy_mode = 1;
    hs0 = n_hs;
    for (int i = 0; i < 1000; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    rdy_mode = 0;
    drain();
    chk("rand_count", 32'(n_hs - hs0), 32'd1000);
    chk("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
